// File: rtl/mmcm_drp_sequencer.sv
// -----------------------------------------------------------------------------
// mmcm_drp_sequencer
//
// Table-driven DRP reconfiguration controller for the 7-series MMCM wrapper
// family. Holds up to NUM_ENTRIES read-modify-write records
// {addr, mask, data}. On start it holds the MMCM in reset and applies each
// record as
//     DI = (DO & mask) | data
// to DRP register addr. It then releases reset and waits for LOCKED.
// Each DRP wait and the lock wait has its own timeout.
//
// Optional build macro:
//   MMCM_DRP_READBACK_EN - re-read every register after writing it. A value
//                          that differs from the written one fails with
//                          err_code 3.
//
// Ports:
//   refclk            DRP/system clock (also forwarded as DCLK)
//   rst               asynchronous active-high reset
//   cfg_we            table write strobe (ignored while busy)
//   cfg_idx           table record index (>= NUM_ENTRIES ignored)
//   cfg_addr          record DRP address
//   cfg_mask          record mask: bits kept from the read value
//   cfg_data          record data: bits OR-ed in after masking
//   cfg_count         number of records to apply, sampled on start
//   start             begin a sequence (accepted only when idle)
//   busy              sequence in progress
//   done              one-cycle pulse on successful completion
//   error             sticky failure flag, cleared by the next accepted start
//   err_code          0 none, 1 drdy timeout, 2 lock timeout, 3 verify mismatch
//   reconfig_to_pll   [15:0] DI, [22:16] DADDR, [23] DEN, [24] DWE,
//                     [25] MMCM reset, [26] DCLK, [63:27] zero
//   reconfig_from_pll [15:0] DO, [16] DRDY, [17] LOCKED, rest ignored
// -----------------------------------------------------------------------------
module mmcm_drp_sequencer #(
    parameter int NUM_ENTRIES  = 8,
    parameter int IDX_W        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [6:0]       cfg_addr,
    input  logic [15:0]      cfg_mask,
    input  logic [15:0]      cfg_data,
    input  logic [IDX_W:0]   cfg_count,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [63:0]      reconfig_to_pll,
    input  logic [63:0]      reconfig_from_pll
);

    // One timer serves every wait state, so size it for the longer limit.
    localparam int TMR_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] DRDY_LIM = TMR_W'(DRDY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LIM = TMR_W'(LOCK_TIMEOUT - 1);

    localparam logic [1:0] ERR_DRDY = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;
`ifdef MMCM_DRP_READBACK_EN
    localparam logic [1:0] ERR_VFY  = 2'd3;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_ON,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
`ifdef MMCM_DRP_READBACK_EN
        S_VFY_REQ,
        S_VFY_WAIT,
`endif
        S_NEXT,
        S_RST_OFF,
        S_LOCK_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             error_reg;
    logic [1:0]       err_code_reg;
    logic [15:0]      di_reg;
    logic [6:0]       daddr_reg;
    logic             den_reg;
    logic             dwe_reg;
    logic             mmcm_rst_reg;
    logic [15:0]      do_cap_reg;
    logic [IDX_W:0]   idx_reg;
    logic [IDX_W:0]   count_reg;
    logic [TMR_W-1:0] timer_reg;
    logic             lock_meta_reg;
    logic             lock_sync_reg;
    logic             lock_prev_reg;

    // From-PLL bus fields.
    logic [15:0] drp_do;
    logic        drp_rdy;
    logic        pll_locked;
    logic        unused_from_bits;

    assign drp_do           = reconfig_from_pll[15:0];
    assign drp_rdy          = reconfig_from_pll[16];
    assign pll_locked       = reconfig_from_pll[17];
    assign unused_from_bits = ^reconfig_from_pll[63:18];

    // ---------------------------------------------------------------
    // Record table: {addr[38:32], mask[31:16], data[15:0]}.
    // Small and read at the current index, so it is kept as plain
    // registers with an asynchronous read port.
    // ---------------------------------------------------------------
    logic [38:0] tbl_mem [NUM_ENTRIES];
    logic [38:0] rec;
    logic [6:0]  rec_addr;
    logic [15:0] rec_mask;
    logic [15:0] rec_data;

    always_ff @(posedge refclk) begin
        if (cfg_we && !busy_reg && (32'(cfg_idx) < NUM_ENTRIES)) begin
            tbl_mem[cfg_idx] <= {cfg_addr, cfg_mask, cfg_data};
        end
    end

    assign rec      = tbl_mem[idx_reg[IDX_W-1:0]];
    assign rec_addr = rec[38:32];
    assign rec_mask = rec[31:16];
    assign rec_data = rec[15:0];

    // Start-time record count, clamped to the table size.
    logic [IDX_W:0] count_clamped;
    logic [IDX_W:0] idx_inc;

    assign count_clamped = (32'(cfg_count) > NUM_ENTRIES) ? (IDX_W+1)'(NUM_ENTRIES) : cfg_count;
    assign idx_inc       = idx_reg + 1'b1;

    // ---------------------------------------------------------------
    // LOCKED synchroniser. The chain is flushed while the sequencer
    // holds the MMCM in reset. A LOCKED level left over from before the
    // reset pulse therefore cannot satisfy the lock check.
    // ---------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
            lock_prev_reg <= 1'b0;
        end else if (mmcm_rst_reg) begin
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
            lock_prev_reg <= 1'b0;
        end else begin
            lock_meta_reg <= pll_locked;
            lock_sync_reg <= lock_meta_reg;
            lock_prev_reg <= lock_sync_reg;
        end
    end

    // ---------------------------------------------------------------
    // Sequencer FSM. Outputs are registered, so a request state's DEN
    // appears on the bus during the first cycle of the matching wait
    // state. The wait timer starts at that same edge. A failure sets
    // error, err_code and the MMCM reset release on the edge that
    // enters FAIL.
    // ---------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            err_code_reg <= 2'd0;
            di_reg       <= 16'd0;
            daddr_reg    <= 7'd0;
            den_reg      <= 1'b0;
            dwe_reg      <= 1'b0;
            mmcm_rst_reg <= 1'b0;
            do_cap_reg   <= 16'd0;
            idx_reg      <= '0;
            count_reg    <= '0;
            timer_reg    <= '0;
        end else begin
            // DRP strobes and done are single-cycle pulses.
            den_reg  <= 1'b0;
            dwe_reg  <= 1'b0;
            done_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        error_reg    <= 1'b0;
                        err_code_reg <= 2'd0;
                        count_reg    <= count_clamped;
                        idx_reg      <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= S_RST_ON;
                    end
                end

                S_RST_ON: begin
                    mmcm_rst_reg <= 1'b1;
                    state_reg    <= (count_reg == '0) ? S_RST_OFF : S_RD_REQ;
                end

                S_RD_REQ: begin
                    den_reg   <= 1'b1;
                    daddr_reg <= rec_addr;
                    timer_reg <= '0;
                    state_reg <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (drp_rdy) begin
                        do_cap_reg <= drp_do;
                        state_reg  <= S_WR_REQ;
                    end else if (timer_reg == DRDY_LIM) begin
                        error_reg    <= 1'b1;
                        err_code_reg <= ERR_DRDY;
                        mmcm_rst_reg <= 1'b0;
                        state_reg    <= S_FAIL;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                S_WR_REQ: begin
                    den_reg   <= 1'b1;
                    dwe_reg   <= 1'b1;
                    di_reg    <= (do_cap_reg & rec_mask) | rec_data;
                    timer_reg <= '0;
                    state_reg <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    if (drp_rdy) begin
`ifdef MMCM_DRP_READBACK_EN
                        state_reg <= S_VFY_REQ;
`else
                        state_reg <= S_NEXT;
`endif
                    end else if (timer_reg == DRDY_LIM) begin
                        error_reg    <= 1'b1;
                        err_code_reg <= ERR_DRDY;
                        mmcm_rst_reg <= 1'b0;
                        state_reg    <= S_FAIL;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

`ifdef MMCM_DRP_READBACK_EN
                // DADDR still holds addr[idx] from the read request.
                S_VFY_REQ: begin
                    den_reg   <= 1'b1;
                    timer_reg <= '0;
                    state_reg <= S_VFY_WAIT;
                end

                S_VFY_WAIT: begin
                    if (drp_rdy) begin
                        if (drp_do != di_reg) begin
                            error_reg    <= 1'b1;
                            err_code_reg <= ERR_VFY;
                            mmcm_rst_reg <= 1'b0;
                            state_reg    <= S_FAIL;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end else if (timer_reg == DRDY_LIM) begin
                        error_reg    <= 1'b1;
                        err_code_reg <= ERR_DRDY;
                        mmcm_rst_reg <= 1'b0;
                        state_reg    <= S_FAIL;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
`endif

                S_NEXT: begin
                    idx_reg   <= idx_inc;
                    state_reg <= (idx_inc == count_reg) ? S_RST_OFF : S_RD_REQ;
                end

                S_RST_OFF: begin
                    mmcm_rst_reg <= 1'b0;
                    timer_reg    <= '0;
                    state_reg    <= S_LOCK_WAIT;
                end

                // Lock is accepted after two consecutive synchronised
                // high samples.
                S_LOCK_WAIT: begin
                    if (lock_sync_reg && lock_prev_reg) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (timer_reg == LOCK_LIM) begin
                        error_reg    <= 1'b1;
                        err_code_reg <= ERR_LOCK;
                        state_reg    <= S_FAIL;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                S_FAIL: begin
                    mmcm_rst_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign error    = error_reg;
    assign err_code = err_code_reg;

    // DCLK is the raw refclk; every other bus field comes from a register.
    assign reconfig_to_pll = {37'd0, refclk, mmcm_rst_reg, dwe_reg, den_reg,
                              daddr_reg, di_reg};

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mmcm_drp_sequencer
//
// Directed bench for mmcm_drp_sequencer. A negedge-driven DRP/MMCM model has
// programmable read/write DRDY latency and lock delay. It can also corrupt
// bit 0 of written data. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mmcm_drp_sequencer;

    localparam int NUM_ENTRIES  = 6;
    localparam int IDX_W        = 3;
    localparam int DRDY_TIMEOUT = 255;
    localparam int LOCK_TIMEOUT = 100;

`ifdef MMCM_DRP_READBACK_EN
    localparam int RD_PER = 2;
`else
    localparam int RD_PER = 1;
`endif

    logic             refclk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [6:0]       cfg_addr;
    logic [15:0]      cfg_mask;
    logic [15:0]      cfg_data;
    logic [IDX_W:0]   cfg_count;
    logic             start;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [63:0]      reconfig_to_pll;
    logic [63:0]      reconfig_from_pll;

    always #5 refclk = ~refclk;

    mmcm_drp_sequencer #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W),
        .DRDY_TIMEOUT(DRDY_TIMEOUT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .refclk           (refclk),
        .rst              (rst),
        .cfg_we           (cfg_we),
        .cfg_idx          (cfg_idx),
        .cfg_addr         (cfg_addr),
        .cfg_mask         (cfg_mask),
        .cfg_data         (cfg_data),
        .cfg_count        (cfg_count),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .err_code         (err_code),
        .reconfig_to_pll  (reconfig_to_pll),
        .reconfig_from_pll(reconfig_from_pll)
    );

    // ---------------- DRP / MMCM model ----------------
    logic [15:0] do_m;
    logic        drdy_m;
    logic        locked_m;
    logic [15:0] mem [128];
    logic [15:0] pend_do;
    int          pend;
    int          rd_lat;
    int          wr_lat;
    int          lock_delay;
    int          lk_cnt;
    bit          corrupt;
    int          rd_cnt;
    int          wr_cnt;
    int          den_no_rst;
    int          den_overlap;
    int          rst_hi_cnt;
    int          done_cnt;
    logic [6:0]  wr_addr_log [64];
    logic [15:0] wr_di_log [64];

    assign reconfig_from_pll = {46'd0, locked_m, drdy_m, do_m};

    always @(negedge refclk) begin
        int lat;
        drdy_m = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                drdy_m = 1'b1;
                do_m   = pend_do;
            end
        end
        if (reconfig_to_pll[23]) begin
            if (pend > 0) den_overlap++;
            if (!reconfig_to_pll[25]) den_no_rst++;
            if (reconfig_to_pll[24]) begin
                if (wr_cnt < 64) begin
                    wr_addr_log[wr_cnt] = reconfig_to_pll[22:16];
                    wr_di_log[wr_cnt]   = reconfig_to_pll[15:0];
                end
                mem[reconfig_to_pll[22:16]] = reconfig_to_pll[15:0] ^ {15'd0, corrupt};
                wr_cnt++;
                pend_do = 16'h0000;
                lat     = wr_lat;
            end else begin
                rd_cnt++;
                pend_do = mem[reconfig_to_pll[22:16]];
                lat     = rd_lat;
            end
            if (lat > 0) pend = lat;
        end
        if (reconfig_to_pll[25]) rst_hi_cnt++;
        if (done) done_cnt++;
        // Lock model: drop on MMCM reset, rise lock_delay cycles after release.
        if (reconfig_to_pll[25]) begin
            locked_m = 1'b0;
            lk_cnt   = 0;
        end else if (lock_delay >= 0) begin
            if (lk_cnt >= lock_delay) locked_m = 1'b1;
            else lk_cnt++;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        pend        = 0;
        drdy_m      = 1'b0;
        do_m        = 16'h0000;
        rd_cnt      = 0;
        wr_cnt      = 0;
        den_no_rst  = 0;
        den_overlap = 0;
        rst_hi_cnt  = 0;
        done_cnt    = 0;
        corrupt     = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
        mem[7'h14] = 16'hA5C3;
    endtask

    task automatic model_quiet();
        @(posedge refclk);
        #1;
        reset_model();
    endtask

    task automatic cfg_write(input int idx, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        @(negedge refclk);
        cfg_idx  = 3'(idx);
        cfg_addr = a;
        cfg_mask = m;
        cfg_data = d;
        cfg_we   = 1'b1;
        @(negedge refclk);
        cfg_we   = 1'b0;
    endtask

    task automatic start_seq(input int cnt);
        @(negedge refclk);
        cfg_count = 4'(cnt);
        start     = 1'b1;
        @(negedge refclk);
        start     = 1'b0;
        check_eq("accept_busy", busy, 1);
        check_eq("accept_error_clear", error, 0);
        check_eq("accept_code_clear", err_code, 0);
    endtask

    task automatic wait_idle();
        bit fin = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            @(negedge refclk);
        end
        #1;
        check_eq("seq_finished", 32'(fin), 1);
        $display("seq: done_pulses=%0d error=%0d err_code=%0d reads=%0d writes=%0d",
                 done_cnt, error, err_code, rd_cnt, wr_cnt);
    endtask

    logic [6:0]  tbl_addr [6];
    logic [15:0] tbl_mask [6];
    logic [15:0] tbl_data [6];
    logic [15:0] exp_di   [6];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tbl_addr = '{7'h08, 7'h09, 7'h14, 7'h15, 7'h28, 7'h4E};
        tbl_mask = '{16'h1000, 16'h8000, 16'h00FF, 16'h0000, 16'hF0F0, 16'h0F00};
        tbl_data = '{16'h0041, 16'h0003, 16'h1200, 16'h5555, 16'h0101, 16'h0000};
        // Hand-computed (mem & mask) | data, mem = 0xFFFF except [0x14] = 0xA5C3.
        exp_di   = '{16'h1041, 16'h8003, 16'h12C3, 16'h5555, 16'hF1F1, 16'h0F00};

        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_addr  = '0;
        cfg_mask  = '0;
        cfg_data  = '0;
        cfg_count = '0;
        start     = 1'b0;
        locked_m  = 1'b0;
        lk_cnt    = 0;
        rd_lat    = 3;
        wr_lat    = 3;
        lock_delay = 10;
        reset_model();

        // Reset state (sampled with refclk low, so DCLK is 0 too).
        repeat (3) @(negedge refclk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_err_code", err_code, 0);
        check_eq("rst_to_pll_lo", reconfig_to_pll[31:0], 0);
        check_eq("rst_to_pll_hi", reconfig_to_pll[63:32], 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) cfg_write(i, tbl_addr[i], tbl_mask[i], tbl_data[i]);
        cfg_write(6, 7'h7F, 16'h0000, 16'hDEAD);   // out of range: dropped

        // DCLK follows refclk, upper bits zero.
        @(posedge refclk);
        #1;
        check_eq("dclk_high", reconfig_to_pll[26], 1);
        check_eq("to_pll_upper_zero", reconfig_to_pll[63:27], 0);

        // Single record, DRDY after 3 cycles, lock 10 cycles after release.
        model_quiet();
        start_seq(1);
        wait_idle();
        check_eq("t1_wr_cnt", wr_cnt, 1);
        check_eq("t1_wr_addr", wr_addr_log[0], 7'h08);
        check_eq("t1_wr_di", wr_di_log[0], 16'h1041);
        check_eq("t1_rd_cnt", rd_cnt, RD_PER);
        check_eq("t1_den_no_rst", den_no_rst, 0);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_error", error, 0);
        check_eq("t1_mmcm_rst", reconfig_to_pll[25], 0);

        // count = 0: one-cycle reset pulse, no DRP traffic.
        model_quiet();
        start_seq(0);
        wait_idle();
        check_eq("t2_rd_cnt", rd_cnt, 0);
        check_eq("t2_wr_cnt", wr_cnt, 0);
        check_eq("t2_rst_cycles", rst_hi_cnt, 1);
        check_eq("t2_done_cnt", done_cnt, 1);
        check_eq("t2_error", error, 0);

        // count 9 is clamped to 6 records.
        model_quiet();
        start_seq(9);
        wait_idle();
        check_eq("t3_wr_cnt", wr_cnt, 6);
        check_eq("t3_rd_cnt", rd_cnt, 6 * RD_PER);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t3_addr%0d", i), wr_addr_log[i], tbl_addr[i]);
            check_eq($sformatf("t3_di%0d", i), wr_di_log[i], exp_di[i]);
        end
        check_eq("t3_overlap", den_overlap, 0);
        check_eq("t3_den_no_rst", den_no_rst, 0);
        check_eq("t3_done_cnt", done_cnt, 1);

        // DRDY on the last allowed wait cycle still succeeds.
        model_quiet();
        rd_lat = DRDY_TIMEOUT - 1;
        start_seq(1);
        wait_idle();
        check_eq("t4_done_cnt", done_cnt, 1);
        check_eq("t4_error", error, 0);
        check_eq("t4_wr_di", wr_di_log[0], 16'h1041);

        // No DRDY at all: 255 wait cycles, then err_code 1.
        model_quiet();
        rd_lat = -1;
        start_seq(1);
        for (int c = 0; c < 50; c++) begin
            if (reconfig_to_pll[23]) break;
            @(negedge refclk);
        end
        n = 0;
        while (!error && n < 1000) begin
            @(negedge refclk);
            n++;
        end
        check_eq("t5_timeout_cycles", n, DRDY_TIMEOUT);
        wait_idle();
        check_eq("t5_error", error, 1);
        check_eq("t5_err_code", err_code, 1);
        check_eq("t5_mmcm_rst", reconfig_to_pll[25], 0);
        check_eq("t5_done_cnt", done_cnt, 0);
        check_eq("t5_wr_cnt", wr_cnt, 0);

        // A later start clears the error and runs cleanly.
        model_quiet();
        rd_lat = 3;
        start_seq(1);
        wait_idle();
        check_eq("t6_done_cnt", done_cnt, 1);
        check_eq("t6_error", error, 0);

        // LOCKED held low: err_code 2 after LOCK_TIMEOUT cycles.
        model_quiet();
        lock_delay = -1;
        locked_m   = 1'b0;
        start_seq(0);
        for (int c = 0; c < 20; c++) begin
            if (reconfig_to_pll[25]) break;
            @(negedge refclk);
        end
        for (int c = 0; c < 20; c++) begin
            if (!reconfig_to_pll[25]) break;
            @(negedge refclk);
        end
        n = 0;
        while (!error && n < 1000) begin
            @(negedge refclk);
            n++;
        end
        check_eq("t7_lock_cycles", n, LOCK_TIMEOUT);
        wait_idle();
        check_eq("t7_error", error, 1);
        check_eq("t7_err_code", err_code, 2);
        check_eq("t7_done_cnt", done_cnt, 0);
        lock_delay = 10;

        // cfg_we and start while busy are both ignored.
        model_quiet();
        rd_lat = 20;
        start_seq(1);
        cfg_idx  = 3'd0;
        cfg_addr = 7'h10;
        cfg_mask = 16'h0000;
        cfg_data = 16'hABCD;
        cfg_we   = 1'b1;
        start    = 1'b1;
        @(negedge refclk);
        cfg_we   = 1'b0;
        start    = 1'b0;
        wait_idle();
        check_eq("t8_wr_cnt", wr_cnt, 1);
        check_eq("t8_wr_addr", wr_addr_log[0], 7'h08);
        check_eq("t8_wr_di", wr_di_log[0], 16'h1041);
        check_eq("t8_done_cnt", done_cnt, 1);
        repeat (5) @(negedge refclk);
        check_eq("t8_no_restart", busy, 0);
        model_quiet();
        rd_lat = 3;
        start_seq(1);
        wait_idle();
        check_eq("t8_rerun_addr", wr_addr_log[0], 7'h08);
        check_eq("t8_rerun_di", wr_di_log[0], 16'h1041);

        // Model corrupts bit 0 of every write.
        model_quiet();
        corrupt = 1'b1;
        start_seq(1);
        wait_idle();
`ifdef MMCM_DRP_READBACK_EN
        check_eq("t9_error", error, 1);
        check_eq("t9_err_code", err_code, 3);
        check_eq("t9_done_cnt", done_cnt, 0);
`else
        check_eq("t9_error", error, 0);
        check_eq("t9_err_code", err_code, 0);
        check_eq("t9_done_cnt", done_cnt, 1);
`endif

        // Asynchronous reset while waiting for write DRDY.
        model_quiet();
        wr_lat = 20;
        start_seq(1);
        for (int c = 0; c < 50; c++) begin
            @(negedge refclk);
            #1;
            if (wr_cnt > 0) break;
        end
        @(negedge refclk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t10_busy", busy, 0);
        check_eq("t10_done", done, 0);
        check_eq("t10_error", error, 0);
        check_eq("t10_err_code", err_code, 0);
        check_eq("t10_to_pll", reconfig_to_pll[31:0], 0);
        @(negedge refclk);
        rst = 1'b0;
        model_quiet();
        wr_lat = 3;
        start_seq(1);
        wait_idle();
        check_eq("t10_rerun_done", done_cnt, 1);
        check_eq("t10_rerun_error", error, 0);
        check_eq("t10_rerun_di", wr_di_log[0], 16'h1041);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmcm_drp_sequencer.md
Name: mmcm_drp_sequencer

Overview:
- Table-driven DRP reconfiguration controller for the 7-series MMCM wrapper family.
- Connects to the wrapper's packed `reconfig_to_pll` / `reconfig_from_pll` buses and replaces per-core hand-written reconfig logic.
- Holds up to NUM_ENTRIES read-modify-write records. On `start` it resets the MMCM, applies every record through the DRP, releases reset and waits for lock, with timeouts and error reporting.

Parameters:
- NUM_ENTRIES, 8, number of table records (1..32).
- IDX_W, $clog2(NUM_ENTRIES) (min 1), table index width.
- DRDY_TIMEOUT, 255, refclk cycles to wait for `drdy` per DRP access.
- LOCK_TIMEOUT, 65535, refclk cycles to wait for `locked` after reset release.

Ports:
- refclk  in  1  DRP/system clock.
- rst  in  1  asynchronous active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  table record index.
- cfg_addr  in  7  DRP register address.
- cfg_mask  in  16  bits to keep from the read value.
- cfg_data  in  16  bits to OR in after masking.
- cfg_count  in  IDX_W+1  records to apply (0..NUM_ENTRIES); sampled on start.
- start  in  1  begin sequence (pulse).
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky failure flag; cleared by next accepted start.
- err_code  out  2  0 none, 1 drdy timeout, 2 lock timeout, 3 verify mismatch.
- reconfig_to_pll  out  64  packed bus (see Behaviour).
- reconfig_from_pll  in  64  packed bus (see Behaviour).

Behaviour:
- Packing, to_pll:
  - [15:0] DI, [22:16] DADDR, [23] DEN, [24] DWE, [25] MMCM reset, [26] DCLK.
  - [26] is driven directly by refclk.
  - [63:27] = 0.
- Packing, from_pll: [15:0] DO, [16] DRDY, [17] LOCKED; other bits ignored.
- Reset values: busy=0, done=0, error=0, err_code=0, all to_pll control bits 0, DI=0, DADDR=0. Table contents are undefined.
- Table writes:
  - cfg_we writes {addr, mask, data} at cfg_idx in one cycle.
  - Ignored while busy=1.
  - cfg_idx ≥ NUM_ENTRIES is ignored.
- start is accepted only in IDLE. Acceptance clears error and err_code, latches cfg_count (clamped to NUM_ENTRIES), sets idx=0 and busy=1 the next cycle. start while busy is ignored.
- FSM states: IDLE → RST_ON → (RD_REQ → RD_WAIT → WR_REQ → WR_WAIT → NEXT)* → RST_OFF → LOCK_WAIT → DONE → IDLE. Any failure goes to FAIL → IDLE.
- RST_ON: assert bit 25 and hold it through NEXT. If cfg_count=0, go straight to RST_OFF.
- RD_REQ:
  - DEN=1 and DADDR=addr[idx] for exactly one cycle, DWE=0.
  - RD_WAIT waits for DRDY and captures DO.
- WR_REQ:
  - DEN=1, DWE=1 for one cycle.
  - DI = (DO_captured & mask[idx]) | data[idx].
  - WR_WAIT waits for DRDY.
- DEN is never asserted while a previous access is outstanding.
- DRDY timeout: each wait state runs a counter reset on entry. If the counter reaches DRDY_TIMEOUT without DRDY, go to FAIL with err_code=1. DRDY in the same cycle as the limit counts as success.
- NEXT: idx++. When idx equals the latched count, go to RST_OFF; otherwise go to RD_REQ.
- RST_OFF: deassert bit 25. Go to LOCK_WAIT.
- LOCK_WAIT:
  - LOCKED is double-registered before use.
  - Success requires the synchronised LOCKED to be high for 2 consecutive cycles.
  - Reaching LOCK_TIMEOUT without success goes to FAIL with err_code=2.
- DONE: done=1 for one cycle, busy=0 next.
- FAIL:
  - Deassert bit 25.
  - Set error=1 and latch err_code; error stays set until the next accepted start.
  - busy=0 next cycle. done is not pulsed.
- Latency: exact cycle count depends on DRDY latency. Each access costs 1 request cycle plus the DRDY wait.
- rst mid-sequence: everything returns to reset values asynchronously, which releases the MMCM reset bit immediately.

Optional Feature:
- Macro: MMCM_DRP_READBACK_EN.
- Defined:
  - After WR_WAIT, add VFY_REQ/VFY_WAIT, which re-read addr[idx] with the same timeout rules.
  - If DO ≠ written DI, go to FAIL with err_code=3.
- Undefined: the verify states are absent and err_code never takes value 3.

Test Plan:
- Table {0x08, mask 0x1000, data 0x0041}, count=1, DRP model returns 0xFFFF after 3 cycles:
  - Write DI=0x1041 at DADDR 0x08.
  - Bit 25 high throughout the DRP phase.
  - LOCKED raised 10 cycles after release → done pulse, error=0.
- count=0, start:
  - Reset pulse with no DEN.
  - done after lock is seen.
- DRP model never returns DRDY on the first read, DRDY_TIMEOUT=255:
  - FAIL after 255 wait cycles, err_code=1, bit 25 deasserted.
  - A later start clears error.
- LOCKED held low, LOCK_TIMEOUT reduced to 100: err_code=2, error=1, no done.
- start and cfg_we while busy: both ignored; the table contents and sequence are unchanged.
- Readback build, model corrupts bit 0 on write: err_code=3.
- Async rst asserted in WR_WAIT: all outputs reach reset values immediately; the next start runs cleanly.
